// File: rtl/shift_deserializer_pkg.sv
// shift_deserializer_pkg: symbol width and state encoding shared with the serializer
package shift_deserializer_pkg;
   localparam int SYMBOL_WIDTH = 4;
   typedef enum logic {IDLE, SHIFT} state_t;
endpackage

// File: rtl/shift_deserializer.sv
// shift_deserializer: LSB-first serial-to-parallel word assembler with valid/ready output and sticky overrun
module shift_deserializer
   import shift_deserializer_pkg::*;
#(
   parameter int WIDTH = SYMBOL_WIDTH
) (
   input  logic             clock,
   input  logic             clear,
   input  logic             serial_in,
   input  logic             shift_in,
   input  logic             start,
   output logic [WIDTH-1:0] parallel_out,
   output logic             word_valid,
   input  logic             word_ready,
   output logic             busy,
   output logic             overrun
);
   localparam int CW = $clog2(WIDTH) + 1;
   state_t state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [WIDTH-1:0] shift_q, shift_d, pout_q, pout_d;
   logic valid_q, valid_d, ovr_q, ovr_d;
   logic complete, xfer, accept;
   assign xfer = valid_q & word_ready;
   assign accept = complete & (~valid_q | xfer);
   assign parallel_out = pout_q;
   assign word_valid = valid_q;
   assign overrun = ovr_q;
   assign busy = (state_q == SHIFT);
   // framing: a start strobe always (re)starts a word; the strobe carrying the last bit completes it
   always_comb begin
      state_d = state_q;
      cnt_d = cnt_q;
      shift_d = shift_q;
      complete = 1'b0;
      if (shift_in && start) begin
         state_d = SHIFT;
         cnt_d = CW'(1);
         shift_d = {shift_q[WIDTH-1:1], serial_in};
      end else if (shift_in && state_q == SHIFT) begin
         shift_d = (shift_q & ~(WIDTH'(1) << cnt_q)) | (WIDTH'(serial_in) << cnt_q);
         cnt_d = cnt_q + CW'(1);
         if (cnt_q == CW'(WIDTH - 1)) begin
            complete = 1'b1;
            state_d = IDLE;
            cnt_d = '0;
         end
      end
   end
   // output register: a finished word loads only if the slot is empty or being drained this cycle
   always_comb begin
      pout_d = accept ? {serial_in, shift_q[WIDTH-2:0]} : pout_q;
      valid_d = accept | (valid_q & ~xfer);
      ovr_d = ovr_q | (complete & ~accept);
   end
   // assembly state: FSM state, bit counter and partial word
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         state_q <= IDLE;
         cnt_q <= '0;
         shift_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q <= cnt_d;
         shift_q <= shift_d;
      end
   end
   // output word, handshake flag and sticky overrun
   always_ff @(posedge clock or posedge clear) begin
      if (clear) begin
         pout_q <= '0;
         valid_q <= 1'b0;
         ovr_q <= 1'b0;
      end else begin
         pout_q <= pout_d;
         valid_q <= valid_d;
         ovr_q <= ovr_d;
      end
   end
endmodule

// File: tb/tb_shift_deserializer.sv
// tb_shift_deserializer: table-driven directed checks of the 4-bit deserializer
module tb_shift_deserializer;
   logic clock = 1'b0;
   logic clear = 1'b1;
   logic serial_in = 1'b0, shift_in = 1'b0, start = 1'b0, word_ready = 1'b0;
   logic [3:0] parallel_out;
   logic word_valid, busy, overrun;
   int checks = 0;
   int failures = 0;

   typedef struct {
      logic sh, st, si, rd;
      logic [3:0] p;
      logic v, b, o;
   } vec_t;
   vec_t q[$];

   shift_deserializer #(.WIDTH(4)) dut (
      .clock(clock), .clear(clear), .serial_in(serial_in), .shift_in(shift_in),
      .start(start), .parallel_out(parallel_out), .word_valid(word_valid),
      .word_ready(word_ready), .busy(busy), .overrun(overrun)
   );

   always #5 clock = ~clock;

   task automatic chk(input string n, input logic [3:0] a, input logic [3:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s got=%h want=%h", n, a, e);
      end
   endtask

   task automatic chk_all(input string n, input logic [3:0] p, input logic v, b, o);
      chk({n, " parallel_out"}, parallel_out, p);
      chk({n, " word_valid"}, {3'b0, word_valid}, {3'b0, v});
      chk({n, " busy"}, {3'b0, busy}, {3'b0, b});
      chk({n, " overrun"}, {3'b0, overrun}, {3'b0, o});
   endtask

   task automatic add(input logic sh, st, si, rd, input logic [3:0] p, input logic v, b, o);
      vec_t x;
      x.sh = sh; x.st = st; x.si = si; x.rd = rd; x.p = p; x.v = v; x.b = b; x.o = o;
      q.push_back(x);
   endtask

   task automatic run_all(input string tag);
      foreach (q[i]) begin
         shift_in = q[i].sh; start = q[i].st; serial_in = q[i].si; word_ready = q[i].rd;
         @(posedge clock);
         #1;
         chk_all($sformatf("%s[%0d]", tag, i), q[i].p, q[i].v, q[i].b, q[i].o);
      end
      q.delete();
      shift_in = 0; start = 0; serial_in = 0; word_ready = 0;
   endtask

   initial begin
      #2;
      chk_all("reset", 4'h0, 0, 0, 0);
      #10 clear = 1'b0;
      // basic word 0xD (bits 1,0,1,1), then consume
      add(1,1,1,0, 4'h0,0,1,0);
      add(1,0,0,0, 4'h0,0,1,0);
      add(1,0,1,0, 4'h0,0,1,0);
      add(1,0,1,0, 4'hD,1,0,0);
      add(0,0,0,1, 4'hD,0,0,0);
      // gapped strobes, busy held through the gaps
      add(1,1,1,0, 4'hD,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 4'hD,0,1,0);
      add(1,0,0,0, 4'hD,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,1,0, 4'hD,0,1,0);
      add(1,0,1,0, 4'hD,0,1,0);
      for (int k = 0; k < 3; k++) add(0,0,0,0, 4'hD,0,1,0);
      add(1,0,1,0, 4'hD,1,0,0);
      add(0,0,0,1, 4'hD,0,0,0);
      // unframed bit ignored in IDLE
      add(1,0,1,0, 4'hD,0,0,0);
      // abort: start,1,1 then restart with 0,0,1,0 -> 0x4
      add(1,1,1,0, 4'hD,0,1,0);
      add(1,0,1,0, 4'hD,0,1,0);
      add(1,1,0,0, 4'hD,0,1,0);
      add(1,0,0,0, 4'hD,0,1,0);
      add(1,0,1,0, 4'hD,0,1,0);
      add(1,0,0,0, 4'h4,1,0,0);
      add(0,0,0,1, 4'h4,0,0,0);
      // back-to-back 0x6 then 0x3 with ready on the completing edge
      add(1,1,0,0, 4'h4,0,1,0);
      add(1,0,1,0, 4'h4,0,1,0);
      add(1,0,1,0, 4'h4,0,1,0);
      add(1,0,0,0, 4'h6,1,0,0);
      add(1,1,1,0, 4'h6,1,1,0);
      add(1,0,1,0, 4'h6,1,1,0);
      add(1,0,0,0, 4'h6,1,1,0);
      add(1,0,0,1, 4'h3,1,0,0);
      add(0,0,0,1, 4'h3,0,0,0);
      // overrun: 0xA kept, 0x5 dropped
      add(1,1,0,0, 4'h3,0,1,0);
      add(1,0,1,0, 4'h3,0,1,0);
      add(1,0,0,0, 4'h3,0,1,0);
      add(1,0,1,0, 4'hA,1,0,0);
      add(1,1,1,0, 4'hA,1,1,0);
      add(1,0,0,0, 4'hA,1,1,0);
      add(1,0,1,0, 4'hA,1,1,0);
      add(1,0,0,0, 4'hA,1,0,1);
      add(0,0,0,0, 4'hA,1,0,1);
      add(0,0,0,1, 4'hA,0,0,1);
      // two bits of a word before the asynchronous clear
      add(1,1,1,0, 4'hA,0,1,1);
      add(1,0,1,0, 4'hA,0,1,1);
      run_all("seq");
      #3 clear = 1'b1;
      #1 chk_all("async_clear", 4'h0, 0, 0, 0);
      @(posedge clock);
      #1 chk_all("clear_held", 4'h0, 0, 0, 0);
      clear = 1'b0;
      add(1,1,1,0, 4'h0,0,1,0);
      add(1,0,1,0, 4'h0,0,1,0);
      add(1,0,1,0, 4'h0,0,1,0);
      add(1,0,1,0, 4'hF,1,0,0);
      add(0,0,0,1, 4'hF,0,0,0);
      run_all("post_clear");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/shift_deserializer.md
# shift_deserializer

Serial-in, parallel-out word assembler for the symbol datapath. It is the receive-side counterpart of the 4-bit parallel-load, right-shifting serializer: it rebuilds WIDTH-bit symbols from a bit stream that is transmitted LSB first. A start marker frames each word. Each assembled word is presented on a registered output with a valid/ready handshake. Overrun is detected and flagged.

## Interface
Parameters:
- WIDTH, default 4. Bits per symbol. Must be 2 or greater.

Ports:
- clock, in, 1. Single clock. All state changes on the rising edge.
- clear, in, 1. Reset. Asynchronous and active-high.
- serial_in, in, 1. Serial data bit. Sampled only when shift_in=1.
- shift_in, in, 1. Bit strobe. Qualifies serial_in for one clock.
- start, in, 1. First-bit marker. Meaningful only when shift_in=1.
- parallel_out, out, WIDTH. Assembled word. serial bit k maps to parallel_out[k].
- word_valid, out, 1. parallel_out holds an unconsumed word.
- word_ready, in, 1. Consumer accepts. A transfer happens when word_valid and word_ready are both 1.
- busy, out, 1. A word is partially assembled (state SHIFT).
- overrun, out, 1. Sticky. A completed word was dropped because the output register was full.

## Operation
- State machine with two states: IDLE and SHIFT.
  - IDLE, shift_in=1, start=1: write serial_in to shift_reg[0], set bit_count=1, go to SHIFT.
  - IDLE, shift_in=1, start=0: ignore the bit (unframed). Stay in IDLE.
  - SHIFT, shift_in=1, start=0: write serial_in to shift_reg[bit_count], increment bit_count.
  - SHIFT, shift_in=1, start=1: abort. Discard the partial word and restart exactly as the IDLE start case. overrun is not set.
  - SHIFT, shift_in=0: hold. Any number of idle cycles is allowed between bits.
- Completion: the strobe that carries bit WIDTH-1 completes the word. The next state is IDLE.
  - If word_valid=0, or a transfer happens in the same cycle: load {serial_in, shift_reg[WIDTH-2:0]} into parallel_out and set word_valid=1.
  - Otherwise: drop the word. overrun←1. parallel_out and word_valid are unchanged.
- Output handshake:
  - A transfer with no completion in the same cycle sets word_valid←0.
  - parallel_out is stable while word_valid=1 and no transfer has happened.
  - Completion and transfer in the same cycle: the new word is loaded and word_valid stays 1.
- Sizes: bit_count is clog2(WIDTH)+1 bits wide. It never wraps, because completion always returns to IDLE.
- overrun clears only on clear.

## Timing
- Reset values (clear asserted): state=IDLE, bit_count=0, shift_reg=0, parallel_out=0, word_valid=0, busy=0, overrun=0.
- Reset takes effect immediately and asynchronously. A partial word is lost when clear is asserted mid-operation.
- Latency: when the last bit is sampled at edge N, parallel_out and word_valid are valid right after edge N.
- Minimum word time is WIDTH clocks, with shift_in held high continuously.
- Back-to-back words:
  - Completion lands in the same cycle start=1 would arrive for the next word. Start can therefore assert on the strobe immediately after completion.
  - Sustained full rate is lossless if word_ready responds within WIDTH-1 cycles.
- busy is registered. It equals (state==SHIFT).
- word_valid does not depend combinationally on word_ready.

## Structure
- Shared package (shared with the serializer): SYMBOL_WIDTH=4 and the state enum {IDLE, SHIFT}.
- No sub-module. State, counter and shift register live in one always block. The output register and handshake live in a second always block.

## Test plan
- Basic word: start on bit 1, then bits 0,1,1 on consecutive strobes, word_ready=0. Required: parallel_out=4'hD, word_valid=1 one edge after the 4th bit, busy back to 0.
- Gapped strobes: the same bits with 3 idle cycles between strobes. Required: identical result (0xD). busy=1 throughout the gaps.
- Abort: start, bits 1,1, then start again with bits 0,0,1,0. Required: parallel_out=4'h4. overrun=0.
- Overrun: two full words 0xA then 0x5 with word_ready=0. Required: parallel_out stays 0xA, overrun=1 after the 2nd word. After a word_ready pulse, word_valid=0.
- Simultaneous events: word_ready=1 on the same edge the 2nd word (0x3) completes. Required: parallel_out=0x3, word_valid stays 1, overrun=0.
- Reset mid-word: assert clear after 2 bits. Required: all outputs 0 at once. The next full word 0xF assembles correctly.
